// File: rtl/mapu_mstream_pkg.sv
// Shared types for the MAPU matrix-stream transpose block.
package mapu_mstream_pkg;

    localparam int unsigned MAT_DIM = 3;
    localparam int unsigned ELEM_W  = 32;
    localparam int unsigned CNT_W   = 16;

    typedef logic [ELEM_W-1:0]    elem_t;
    typedef elem_t [MAT_DIM-1:0]  beat_t;   // one lane per row/column position
    typedef beat_t [MAT_DIM-1:0]  mat_t;    // mat[row][col]
    typedef logic [1:0]           idx_t;

    localparam idx_t LAST_IDX = idx_t'(MAT_DIM - 1);

endpackage

// File: rtl/mapu_mstream_transpose_bank.sv
// One 3x3 matrix buffer: column-wise write, row- or column-wise read.
module mapu_mstream_transpose_bank
    import mapu_mstream_pkg::*;
(
    input  logic  sys_clk,
    input  logic  reset_n,
    input  logic  we,
    input  idx_t  col,
    input  beat_t wdata,
    input  idx_t  rd_idx,
    input  logic  byp,
    output beat_t rdata
);

    mat_t m;

    // Store an incoming column beat into column 'col'.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= '0;
        end else if (we) begin
            for (int unsigned r = 0; r < MAT_DIM; r++) begin
                m[idx_t'(r)][col] <= wdata[idx_t'(r)];
            end
        end
    end

    // Read row rd_idx (transpose) or column rd_idx (bypass, original order).
    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < MAT_DIM; k++) begin
            rdata[idx_t'(k)] = byp ? m[idx_t'(k)][rd_idx] : m[rd_idx][idx_t'(k)];
        end
    end

endmodule

// File: rtl/mapu_mstream_transpose.sv
// Ping-pong 3x3 transposer for the MAPU matrix stream: columns in, rows out.
module mapu_mstream_transpose
    import mapu_mstream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ELEM_W
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  cfg_bypass,
    input  logic                  ig_vld,
    output logic                  ig_rdy,
    input  logic [DATA_WIDTH-1:0] ig_r0,
    input  logic [DATA_WIDTH-1:0] ig_r1,
    input  logic [DATA_WIDTH-1:0] ig_r2,
    output logic                  eg_vld,
    input  logic                  eg_rdy,
    output logic [DATA_WIDTH-1:0] eg_r0,
    output logic [DATA_WIDTH-1:0] eg_r1,
    output logic [DATA_WIDTH-1:0] eg_r2,
    output logic [CNT_W-1:0]      mat_cnt
);

    logic             wr_bank, wr_bank_n;
    logic             rd_bank, rd_bank_n;
    idx_t             wr_col,  wr_col_n;
    idx_t             rd_row,  rd_row_n;
    logic [1:0]       full,    full_n;
    logic [1:0]       byp,     byp_n;
    logic [CNT_W-1:0] mat_cnt_n;
    logic             ig_rdy_n, eg_vld_n;
    logic             ig_fire, eg_fire;
    beat_t            wbeat;
    beat_t            bank_rd [2];
    beat_t            rd_beat;

    assign ig_fire = ig_vld && ig_rdy;
    assign eg_fire = eg_vld && eg_rdy;

    assign wbeat[0] = elem_t'(ig_r0);
    assign wbeat[1] = elem_t'(ig_r1);
    assign wbeat[2] = elem_t'(ig_r2);

    // Two banks: one fills while the other drains.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        mapu_mstream_transpose_bank u_bank (
            .sys_clk (sys_clk),
            .reset_n (reset_n),
            .we      (ig_fire && (wr_bank == 1'(b))),
            .col     (wr_col),
            .wdata   (wbeat),
            .rd_idx  (rd_row),
            .byp     (byp[b]),
            .rdata   (bank_rd[b])
        );
    end

    // Egress lanes are a mux of the flopped bank storage.
    assign rd_beat = bank_rd[rd_bank];
    assign eg_r0   = DATA_WIDTH'(rd_beat[0]);
    assign eg_r1   = DATA_WIDTH'(rd_beat[1]);
    assign eg_r2   = DATA_WIDTH'(rd_beat[2]);

    // Pointer, full-flag and counter next state; ready/valid follow the new flags.
    always_comb begin
        wr_bank_n = wr_bank;
        wr_col_n  = wr_col;
        rd_bank_n = rd_bank;
        rd_row_n  = rd_row;
        full_n    = full;
        byp_n     = byp;
        mat_cnt_n = mat_cnt;

        if (ig_fire) begin
            if (wr_col == '0) begin
                byp_n[wr_bank] = cfg_bypass;
            end
            if (wr_col == LAST_IDX) begin
                full_n[wr_bank] = 1'b1;
                wr_bank_n       = ~wr_bank;
                wr_col_n        = '0;
            end else begin
                wr_col_n = wr_col + idx_t'(1);
            end
        end

        // Set and clear always hit different banks, so both apply.
        if (eg_fire) begin
            if (rd_row == LAST_IDX) begin
                full_n[rd_bank] = 1'b0;
                rd_bank_n       = ~rd_bank;
                rd_row_n        = '0;
                mat_cnt_n       = mat_cnt + CNT_W'(1);
            end else begin
                rd_row_n = rd_row + idx_t'(1);
            end
        end

        ig_rdy_n = ~full_n[wr_bank_n];
        eg_vld_n = full_n[rd_bank_n];
    end

    // State and handshake flops.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_col  <= '0;
            rd_row  <= '0;
            full    <= '0;
            byp     <= '0;
            mat_cnt <= '0;
            ig_rdy  <= 1'b1;
            eg_vld  <= 1'b0;
        end else begin
            wr_bank <= wr_bank_n;
            rd_bank <= rd_bank_n;
            wr_col  <= wr_col_n;
            rd_row  <= rd_row_n;
            full    <= full_n;
            byp     <= byp_n;
            mat_cnt <= mat_cnt_n;
            ig_rdy  <= ig_rdy_n;
            eg_vld  <= eg_vld_n;
        end
    end

endmodule

// File: tb/tb_mapu_mstream_transpose.sv
// Directed bench for mapu_mstream_transpose.
module tb_mapu_mstream_transpose;

    logic        sys_clk;
    logic        reset_n;
    logic        cfg_bypass;
    logic        ig_vld;
    logic        ig_rdy;
    logic [31:0] ig_r0, ig_r1, ig_r2;
    logic        eg_vld;
    logic        eg_rdy;
    logic [31:0] eg_r0, eg_r1, eg_r2;
    logic [15:0] mat_cnt;

    int          n_checks;
    int          n_fail;
    int          cyc;
    bit          watch_rdy;
    bit          rdy_drop;
    logic [95:0] got [$];
    int          got_cyc [$];

    mapu_mstream_transpose #(.DATA_WIDTH(32)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .cfg_bypass (cfg_bypass),
        .ig_vld     (ig_vld),
        .ig_rdy     (ig_rdy),
        .ig_r0      (ig_r0),
        .ig_r1      (ig_r1),
        .ig_r2      (ig_r2),
        .eg_vld     (eg_vld),
        .eg_rdy     (eg_rdy),
        .eg_r0      (eg_r0),
        .eg_r1      (eg_r1),
        .eg_r2      (eg_r2),
        .mat_cnt    (mat_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Element M[r][c] of test matrix m.
    function automatic logic [31:0] el(input int m, input int r, input int c);
        return 32'(m * 16 + r * 3 + c + 1);
    endfunction

    function automatic logic [95:0] col_beat(input int m, input int c);
        return {el(m, 2, c), el(m, 1, c), el(m, 0, c)};
    endfunction

    function automatic logic [95:0] row_beat(input int m, input int j);
        return {el(m, j, 2), el(m, j, 1), el(m, j, 0)};
    endfunction

    function automatic logic [95:0] eg_now();
        return {eg_r2, eg_r1, eg_r0};
    endfunction

    // One clock: log the egress transfer about to happen, then advance to the next negedge.
    task automatic tick();
        if (watch_rdy && ig_vld && !ig_rdy) rdy_drop = 1'b1;
        if (eg_vld && eg_rdy) begin
            got.push_back(eg_now());
            got_cyc.push_back(cyc);
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
    endtask

    task automatic send_beat(input logic [95:0] b, input logic byp);
        logic acc;
        acc        = 1'b0;
        ig_vld     = 1'b1;
        ig_r0      = b[31:0];
        ig_r1      = b[63:32];
        ig_r2      = b[95:64];
        cfg_bypass = byp;
        for (int i = 0; i < 100; i++) begin
            acc = ig_rdy;
            tick();
            if (acc) break;
        end
        if (!acc) check("ig_accept_timeout", 96'(acc), 96'(1));
    endtask

    task automatic send_mat(input int m, input logic [2:0] byps);
        for (int c = 0; c < 3; c++) send_beat(col_beat(m, c), byps[c]);
        ig_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        ig_vld = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_mat(input string tag, input int base, input int m, input bit transposed);
        logic [95:0] obs, exp;
        for (int j = 0; j < 3; j++) begin
            obs = (base + j < got.size()) ? got[base + j] : 'x;
            exp = transposed ? row_beat(m, j) : col_beat(m, j);
            check($sformatf("%s_beat%0d", tag, j), obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        ig_vld     = 1'b0;
        eg_rdy     = 1'b0;
        cfg_bypass = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        reset_n = 1'b1;
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        watch_rdy  = 1'b0;
        rdy_drop   = 1'b0;
        reset_n    = 1'b0;
        cfg_bypass = 1'b0;
        ig_vld     = 1'b0;
        ig_r0      = '0;
        ig_r1      = '0;
        ig_r2      = '0;
        eg_rdy     = 1'b0;
        @(negedge sys_clk);

        // Reset values
        check("rst_ig_rdy",  96'(ig_rdy),   96'(1));
        check("rst_eg_vld",  96'(eg_vld),   96'(0));
        check("rst_eg_data", eg_now(),      96'(0));
        check("rst_mat_cnt", 96'(mat_cnt),  96'(0));
        reset_n = 1'b1;
        @(negedge sys_clk);

        // Single matrix, transposed; first row visible right after the 3rd beat
        eg_rdy = 1'b1;
        send_mat(0, 3'b000);
        check("t1_eg_vld_latency", 96'(eg_vld), 96'(1));
        check("t1_row0_latency",   eg_now(),    {32'd3, 32'd2, 32'd1});
        idle(5);
        check("t1_count", 96'(got.size()), 96'(3));
        check("t1_row0", got[0], {32'd3, 32'd2, 32'd1});
        check("t1_row1", got[1], {32'd6, 32'd5, 32'd4});
        check("t1_row2", got[2], {32'd9, 32'd8, 32'd7});
        check("t1_mat_cnt", 96'(mat_cnt), 96'(1));

        // Back-to-back: 4 matrices, full throughput
        do_reset();
        eg_rdy    = 1'b1;
        watch_rdy = 1'b1;
        for (int m = 0; m < 4; m++) send_mat(m, 3'b000);
        watch_rdy = 1'b0;
        idle(8);
        check("t2_rdy_drop", 96'(rdy_drop), 96'(0));
        check("t2_count", 96'(got.size()), 96'(12));
        for (int m = 0; m < 4; m++) check_mat($sformatf("t2_m%0d", m), 3 * m, m, 1'b1);
        check("t2_consecutive", 96'(got_cyc[11] - got_cyc[0]), 96'(11));
        check("t2_mat_cnt", 96'(mat_cnt), 96'(4));

        // Backpressure: both banks fill, then drain
        do_reset();
        send_mat(0, 3'b000);
        send_mat(1, 3'b000);
        check("t3_ig_rdy_full", 96'(ig_rdy), 96'(0));
        check("t3_eg_vld_held", 96'(eg_vld), 96'(1));
        ig_vld = 1'b1;
        ig_r0  = col_beat(2, 0)[31:0];
        ig_r1  = col_beat(2, 0)[63:32];
        ig_r2  = col_beat(2, 0)[95:64];
        repeat (3) tick();
        check("t3_ig_rdy_stall", 96'(ig_rdy), 96'(0));
        check("t3_eg_stable",    eg_now(),    row_beat(0, 0));
        check("t3_eg_vld_stall", 96'(eg_vld), 96'(1));
        eg_rdy = 1'b1;
        tick();
        check("t3_ig_rdy_row0", 96'(ig_rdy), 96'(0));
        tick();
        check("t3_ig_rdy_row1", 96'(ig_rdy), 96'(0));
        tick();
        check("t3_ig_rdy_row2", 96'(ig_rdy), 96'(1));
        send_mat(2, 3'b000);
        idle(10);
        check("t3_count", 96'(got.size()), 96'(9));
        for (int m = 0; m < 3; m++) check_mat($sformatf("t3_m%0d", m), 3 * m, m, 1'b1);
        check("t3_mat_cnt", 96'(mat_cnt), 96'(3));

        // Bypass latched on the first beat only; next matrix transposed
        do_reset();
        eg_rdy = 1'b1;
        send_mat(5, 3'b001);
        send_mat(6, 3'b000);
        idle(8);
        check("t4_count", 96'(got.size()), 96'(6));
        check_mat("t4_bypass", 0, 5, 1'b0);
        check_mat("t4_transp", 3, 6, 1'b1);
        check("t4_mat_cnt", 96'(mat_cnt), 96'(2));

        // Reset with one stored matrix and a partial one
        got.delete();
        eg_rdy = 1'b0;
        send_mat(7, 3'b000);
        send_beat(col_beat(8, 0), 1'b0);
        send_beat(col_beat(8, 1), 1'b0);
        ig_vld = 1'b0;
        check("t5_pre_eg_vld",  96'(eg_vld),  96'(1));
        check("t5_pre_mat_cnt", 96'(mat_cnt), 96'(2));
        reset_n = 1'b0;
        #1;
        check("t5_rst_eg_vld",  96'(eg_vld),  96'(0));
        check("t5_rst_ig_rdy",  96'(ig_rdy),  96'(1));
        check("t5_rst_mat_cnt", 96'(mat_cnt), 96'(0));
        @(negedge sys_clk);
        reset_n = 1'b1;
        eg_rdy  = 1'b1;
        idle(3);
        check("t5_no_beats", 96'(got.size()), 96'(0));
        send_mat(9, 3'b000);
        idle(5);
        check("t5_count", 96'(got.size()), 96'(3));
        check_mat("t5_m9", 0, 9, 1'b1);
        check("t5_mat_cnt", 96'(mat_cnt), 96'(1));

        // Counter wrap from 0xFFFF
        got.delete();
        force dut.mat_cnt = 16'hFFFF;
        tick();
        release dut.mat_cnt;
        check("t6_preload", 96'(mat_cnt), 96'(16'hFFFF));
        send_mat(3, 3'b000);
        idle(5);
        check_mat("t6_m3", 0, 3, 1'b1);
        check("t6_wrap", 96'(mat_cnt), 96'(16'h0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
